// File: rtl/rca_sub_serial.sv
// Bit-serial ripple-carry inverter: recovers b from s = a + b, LSB first.
// Optional range_err output under RCA_SUB_RANGE_ERR_EN.
module rca_sub_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   s,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] b,
   output logic             busy
`ifdef RCA_SUB_RANGE_ERR_EN
   ,
   output logic             range_err
`endif
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [WIDTH-1:0] s_lo;
   logic [WIDTH-1:0] a_q;
   logic             s_msb;
   logic             brw;
   logic [IW-1:0]    idx;

   logic s_bit;
   logic a_bit;
   logic d;
   logic brw_n;
   logic last;

   assign s_bit = s_lo[idx];
   assign a_bit = a_q[idx];
   assign d     = s_bit ^ a_bit ^ brw;
   assign brw_n = (~s_bit & a_bit) | (~(s_bit ^ a_bit) & brw);
   assign last  = (idx == LAST);

   assign in_ready = (state == IDLE);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (in_valid) state_n = SHIFT;
         SHIFT:   if (last) state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         out_valid <= (state_n == DONE);
         busy      <= (state_n != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_lo  <= '0;
         s_msb <= 1'b0;
         a_q   <= '0;
         b     <= '0;
         brw   <= 1'b0;
         idx   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  s_lo  <= s[WIDTH-1:0];
                  s_msb <= s[WIDTH];
                  a_q   <= a;
                  brw   <= 1'b0;
                  idx   <= '0;
               end
            end
            SHIFT: begin
               b[idx] <= d;
               brw    <= brw_n;
               idx    <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef RCA_SUB_RANGE_ERR_EN
   // Carry-out of the sum minus final borrow: nonzero means out of range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range_err <= 1'b0;
      end else if (state == SHIFT && last) begin
         range_err <= s_msb ^ brw_n;
      end else if (state == DONE && out_ready) begin
         range_err <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_rca_sub_serial.sv
// Self-checking bench for rca_sub_serial (WIDTH=4).
// Range-error checks are active when RCA_SUB_RANGE_ERR_EN is defined.
module tb_rca_sub_serial;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W:0]   s = '0;
   logic [W-1:0] a = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] b;
   logic         busy;
`ifdef RCA_SUB_RANGE_ERR_EN
   logic         range_err;
`endif

   int checks = 0;
   int errors = 0;

   rca_sub_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s         (s),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .b         (b),
      .busy      (busy)
`ifdef RCA_SUB_RANGE_ERR_EN
      ,
      .range_err (range_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one job in flight, result = s - a.
   bit           m_active;
   int           m_cnt;
   logic [W-1:0] m_b;
   logic         m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_cnt    = 0;
         m_b      = '0;
         m_err    = 1'b0;
      end else if (!m_active) begin
         if (in_valid) begin
            int diff;
            diff     = int'(s) - int'(a);
            m_active = 1'b1;
            m_cnt    = 0;
            m_b      = W'(diff);
            m_err    = (diff < 0) || (diff >= (1 << W));
         end
      end else if (m_cnt < W) begin
         m_cnt++;
      end else if (out_ready) begin
         m_active = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         logic ev;
         ev = m_active && (m_cnt == W);
         chk("in_ready", in_ready, !m_active);
         chk("busy", busy, m_active);
         chk("out_valid", out_valid, ev);
         if (ev) begin
            chk("b", b, m_b);
`ifdef RCA_SUB_RANGE_ERR_EN
            chk("range_err", range_err, m_err);
`endif
         end
      end
   end

   // Caller is positioned at a negedge; inputs change here.
   task automatic run_op(input logic [W:0] sv,
                         input logic [W-1:0] av,
                         input logic [W-1:0] eb,
                         input logic ee,
                         input int hold,
                         input string tag);
      bit seen;
      s        = sv;
      a        = av;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 30 && !seen; n++) begin
         if (out_valid) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 0, 1);
         return;
      end
      chk({tag, "_b"}, b, eb);
`ifdef RCA_SUB_RANGE_ERR_EN
      chk({tag, "_err"}, range_err, ee);
`else
      if (ee !== 1'bx) ;
`endif
      for (int h = 0; h < hold; h++) begin
         in_valid = ~in_valid;
         s        = s ^ 5'b10101;
         a        = a + 4'd3;
         @(negedge clk);
         chk({tag, "_hold_b"}, b, eb);
         chk({tag, "_hold_rdy"}, in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle"}, in_ready, 1'b1);
   endtask

   initial begin
      #2;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_b", b, 4'b0000);
`ifdef RCA_SUB_RANGE_ERR_EN
      chk("rst_err", range_err, 1'b0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(5'b01001, 4'b0011, 4'b0110, 1'b0, 0, "v028");
      run_op(5'b10010, 4'b0011, 4'b1111, 1'b0, 0, "v029");
      run_op(5'b00010, 4'b0101, 4'b1101, 1'b1, 0, "v030a");
      run_op(5'b11111, 4'b1111, 4'b0000, 1'b1, 3, "v030b");
      run_op(5'b00000, 4'b0000, 4'b0000, 1'b0, 0, "zero");
      run_op(5'b10000, 4'b0000, 4'b0000, 1'b1, 1, "ovf");
      run_op(5'b01111, 4'b0000, 4'b1111, 1'b0, 0, "max");

      // Abort mid-SHIFT after two bits have been processed.
      s        = 5'b01110;
      a        = 4'b0001;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_pre", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_b", b, 4'b0000);
`ifdef RCA_SUB_RANGE_ERR_EN
      chk("abort_err", range_err, 1'b0);
`endif
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_discard", busy, 1'b0);
      run_op(5'b01001, 4'b0011, 4'b0110, 1'b0, 0, "post");

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
